// File: rtl/ball_motion_ctrl.sv
// Projectile controller for a basketball shot: launch, per-frame ballistic update, score/miss, timed hold.
// Frame updates land one cycle after frame_tick; launch is dropped (not queued) while busy.
module ball_motion_ctrl #(
  parameter int X_START     = 80,
  parameter int Y_START     = 400,
  parameter int HOOP_X0     = 520,
  parameter int HOOP_X1     = 560,
  parameter int HOOP_Y      = 200,
  parameter int X_MAX       = 639,
  parameter int Y_FLOOR     = 470,
  parameter int GRAVITY     = 1,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [4:0] vx_init,
  input  logic [5:0] vy_init,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       busy,
  output logic       scored,
  output logic       missed,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLIGHT = 2'd1,
    S_RESULT = 2'd2
  } state_e;

  localparam int CNT_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic signed [10:0] HOOP_X0_S = 11'(HOOP_X0);
  localparam logic signed [10:0] HOOP_X1_S = 11'(HOOP_X1);
  localparam logic signed [10:0] HOOP_Y_S  = 11'(HOOP_Y);
  localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] Y_FLOOR_S = 11'(Y_FLOOR);

  state_e                  state_q, state_d;
  logic        [9:0]       x_q, x_d;
  logic        [9:0]       y_q, y_d;
  logic        [4:0]       vx_q, vx_d;
  logic signed [7:0]       vy_q, vy_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    scored_q, scored_d;
  logic                    missed_q, missed_d;

  logic signed [10:0]      x_n, y_n;
  logic signed [8:0]       vy_sum;
  logic        [CNT_W-1:0] cnt_inc;
  logic                    hit, miss;

  always_comb begin
    // 11-bit signed sums leave headroom so nothing wraps before the clamps act
    x_n     = $signed({1'b0, x_q}) + $signed({6'b000000, vx_q});
    y_n     = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
    vy_sum  = $signed({vy_q[7], vy_q}) + $signed(9'(GRAVITY));
    cnt_inc = cnt_q + CNT_W'(1);
    hit     = (vy_q > 8'sd0) && (y_q < 10'(HOOP_Y)) && (y_n >= HOOP_Y_S)
              && (x_n >= HOOP_X0_S) && (x_n <= HOOP_X1_S);
    miss    = (x_n >= X_MAX_S) || (y_n >= Y_FLOOR_S);

    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    cnt_d    = cnt_q;
    scored_d = 1'b0;
    missed_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          vx_d    = vx_init;
          vy_d    = -$signed({2'b00, vy_init});
          x_d     = 10'(X_START);
          y_d     = 10'(Y_START);
          state_d = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (frame_tick) begin
          vy_d = (vy_sum > 9'sd127) ? 8'sd127 : vy_sum[7:0];
          x_d  = x_n[9:0];
          y_d  = y_n[10] ? 10'd0 : y_n[9:0];
          if (hit) begin
            scored_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_RESULT;
          end else if (miss) begin
            if (x_n >= X_MAX_S)   x_d = 10'(X_MAX);
            if (y_n >= Y_FLOOR_S) y_d = 10'(Y_FLOOR);
            missed_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (frame_tick) begin
          if (cnt_inc == CNT_W'(HOLD_FRAMES)) begin
            cnt_d   = '0;
            x_d     = 10'(X_START);
            y_d     = 10'(Y_START);
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= 10'(X_START);
      y_q      <= 10'(Y_START);
      vx_q     <= '0;
      vy_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      scored_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      scored_q <= scored_d;
      missed_q <= missed_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign busy   = busy_q;
  assign scored = scored_q;
  assign missed = missed_q;
  assign state  = state_q;

endmodule
